// File: rtl/inv_mixcolumn_seq.sv
// inv_mixcolumn_seq: sequential InvMixColumns over a selectable GF(2^8) field, one column per cycle.
// Define INV_MC_DUAL_COLUMN_EN to process two columns per cycle (halves the CALC phase).
module inv_mixcolumn_seq #(
    parameter logic [8:0] STD_POLY  = 9'h11B,
    parameter logic [8:0] CUST_POLY = 9'h1A9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         indx,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [1:0]   fsm_state
);
    // Handshake: a transfer occurs on a rising clk edge where valid and ready are both 1;
    // valid never waits on ready, and payload is held stable while valid=1 and ready=0.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

`ifdef INV_MC_DUAL_COLUMN_EN
    localparam int COLS_PER_CYCLE = 2;
    localparam int CNT_W          = 1;
`else
    localparam int COLS_PER_CYCLE = 1;
    localparam int CNT_W          = 2;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    logic [1:0]       state;
    logic [CNT_W-1:0] col_cnt;
    logic [127:0]     data_q;
    logic [127:0]     data_next;
    logic             indx_q;
    logic [8:0]       poly;

    function automatic logic [7:0] xtime(input logic [7:0] b, input logic [8:0] p);
        logic [8:0] s;
        s = {b, 1'b0};
        if (s[8]) s = s ^ p;
        return s[7:0];
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] col, input logic [8:0] p);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i], p);
            x4    = xtime(x2, p);
            x8    = xtime(x4, p);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        // Row i of the circulant matrix {0E,0B,0D,09} rotated right by i.
        res = '0;
        for (int i = 0; i < 4; i++) begin
            res[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
        end
        return res;
    endfunction

    assign poly = indx_q ? STD_POLY : CUST_POLY;

    always_comb begin
        data_next = out_data;
        for (int c = 0; c < 4; c++) begin
            if (state == CALC && col_cnt == CNT_W'(c / COLS_PER_CYCLE)) begin
                data_next[127-32*c -: 32] = inv_col(data_q[127-32*c -: 32], poly);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            col_cnt  <= '0;
            out_data <= '0;
            data_q   <= '0;
            indx_q   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        indx_q <= indx;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    out_data <= data_next;
                    col_cnt  <= col_cnt + CNT_W'(1);
                    if (col_cnt == CNT_LAST) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rst_n so nothing is accepted while reset is still held.
    assign in_ready  = rst_n & (state == IDLE);
    assign out_valid = (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_inv_mixcolumn_seq.sv
// Bench for inv_mixcolumn_seq: transaction-level reference model with a negedge compare process.
// Honours INV_MC_DUAL_COLUMN_EN for latency and throughput expectations.
module tb_inv_mixcolumn_seq;
`ifdef INV_MC_DUAL_COLUMN_EN
    localparam int LAT  = 2;
    localparam int THRU = 4;
`else
    localparam int LAT  = 4;
    localparam int THRU = 6;
`endif
    localparam logic [8:0]   STD   = 9'h11B;
    localparam logic [8:0]   CUST  = 9'h1A9;
    localparam logic [127:0] V_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V_ID  = 128'h5a5a5a5a_00000000_ffffffff_13131313;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         indx = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [1:0]   fsm_state;

    int checks = 0;
    int errors = 0;
    int snap = 0;
    int accept_snap = 0;
    int cyc = 0;
    logic rand_bp = 1'b0;
    logic busy, ev;
    logic [127:0] exp_q[$];
    logic [127:0] exp_hold = '0;

    inv_mixcolumn_seq dut (
        .clk(clk), .rst_n(rst_n), .indx(indx), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // reference model: shift-and-add field multiply, matrix product per column
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b, input logic [8:0] p);
        logic [8:0] aa;
        logic [7:0] acc;
        aa  = {1'b0, a};
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa = aa ^ p;
        end
        return acc;
    endfunction

    function automatic logic [127:0] ref_imc(input logic [127:0] d, input logic x);
        logic [7:0]   coef [4];
        logic [8:0]   p;
        logic [7:0]   acc;
        logic [127:0] res;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        p   = x ? STD : CUST;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(d[127-32*c-8*j -: 8], coef[(j-r+4)%4], p);
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard / compare process: the negedge snapshot is what the next rising edge will see
    always @(negedge clk) begin
        snap++;
        if (!rst_n) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            exp_q.delete();
            exp_hold = '0;
        end else begin
            busy = (exp_q.size() != 0);
            ev   = busy && (snap >= accept_snap + LAT + 1);
            check("in_ready", in_ready, !busy);
            check("out_valid", out_valid, ev);
            if (ev) check("out_data", out_data, exp_q[0]);
            else if (!busy) check("idle_out_data", out_data, exp_hold);
            if (in_valid && !busy) begin
                exp_q.push_back(ref_imc(in_data, indx));
                accept_snap = snap;
            end else if (ev && out_ready) begin
                exp_hold = exp_q.pop_front();
            end
        end
    end

    // driver tasks
    task automatic rand_ready();
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [127:0] d, input logic x, input logic scramble);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        indx     = x;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk); #1;
            rand_ready();
        end
        if (n == 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready never seen within %0d cycles", n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (scramble) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            indx    = 1'($urandom_range(0, 1));
        end
        rand_ready();
    endtask

    task automatic wait_valid(output int k);
        for (k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
    endtask

    initial begin
        int k;
        int prev;
        logic [127:0] hold;

        check("pin_gmul_std", gmul(8'h80, 8'h02, STD), 8'h1b);
        check("pin_gmul_cust", gmul(8'h80, 8'h02, CUST), 8'ha9);
        check("pin_model_vec", ref_imc(V_IN, 1'b1), V_OUT);
        check("pin_model_ident", ref_imc(V_ID, 1'b0), V_ID);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // known vector with inputs scrambled during CALC, then backpressure
        send(V_IN, 1'b1, 1'b1);
        wait_valid(k);
        check("lat_vec", k, LAT);
        check("data_vec", out_data, V_OUT);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_data = {$urandom, $urandom, $urandom, $urandom};
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, V_OUT);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);

        // uniform columns pass through unchanged in the custom field
        send(V_ID, 1'b0, 1'b1);
        wait_valid(k);
        check("lat_ident", k, LAT);
        check("data_ident", out_data, V_ID);
        @(posedge clk); #1;

        // reset during the second CALC cycle
        send(V_IN, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("postrst_in_ready", in_ready, 1);
        check("postrst_out_valid", out_valid, 0);
        check("postrst_out_data", out_data, 0);
        send(V_IN, 1'b1, 1'b1);
        wait_valid(k);
        check("postrst_lat", k, LAT);
        check("postrst_data", out_data, V_OUT);

        // back-to-back throughput
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            hold = {$urandom, $urandom, $urandom, $urandom};
            send(hold, 1'($urandom_range(0, 1)), 1'b0);
            if (i > 0) check("b2b_spacing", cyc - prev, THRU);
            prev = cyc;
        end

        // random traffic with random backpressure and gaps
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                rand_ready();
            end
            send({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
        end
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
        end
        repeat (2) @(posedge clk);
        #1 check("drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, %0d cycles elapsed", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
